// File: rtl/vga_timing_checker.sv
// VGA timing monitor: measures hsync/vsync/active_video against the configured
// timing and locks after a clean frame. Define VGA_CHK_POS_EN to add rec_x/rec_y.
module vga_timing_checker #(
   parameter int H_VISIBLE = 640,
   parameter int H_SYNC    = 96,
   parameter int H_TOTAL   = 800,
   parameter int V_VISIBLE = 480,
   parameter int V_SYNC    = 2,
   parameter int V_TOTAL   = 525
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        active_video,
   input  logic        clr_err,
   output logic        locked,
   output logic [5:0]  err_flags,
   output logic [15:0] frame_count
`ifdef VGA_CHK_POS_EN
   ,
   output logic [10:0] rec_x,
   output logic [9:0]  rec_y
`endif
);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   state_t      state, state_nxt;
   logic        hs_q, vs_q, av_q;
   logic        hs_fall, hs_rise, vs_fall, vs_rise, av_rise, av_fall;
   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;
   logic [10:0] av_run;
   logic [9:0]  a_lines;
   logic [9:0]  a_lines_cur;
   logic        a_inc;
   logic        line_act;
   logic        h_armed;
   logic [5:0]  err_set;

   assign hs_fall = hs_q & ~hsync;
   assign hs_rise = ~hs_q & hsync;
   assign vs_fall = vs_q & ~vsync;
   assign vs_rise = ~vs_q & vsync;
   assign av_rise = ~av_q & active_video;
   assign av_fall = av_q & ~active_video;

   // A run ending on the same clock as the frame must count toward that frame
   assign a_inc       = av_fall && !line_act && (a_lines != '1);
   assign a_lines_cur = a_lines + (a_inc ? 10'd1 : 10'd0);

   always_comb begin
      err_set = '0;
      if (state != SEARCH) begin
         err_set[0] = hs_rise && (h_cnt != 11'(H_SYNC));
         err_set[1] = hs_fall && h_armed && (h_cnt != 11'(H_TOTAL));
         err_set[2] = av_fall && (av_run != 11'(H_VISIBLE));
         err_set[3] = vs_rise && (v_cnt != 10'(V_SYNC));
         err_set[4] = vs_fall && (v_cnt != 10'(V_TOTAL));
         err_set[5] = vs_fall && (a_lines_cur != 10'(V_VISIBLE));
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SEARCH:  if (vs_fall) state_nxt = MEASURE;
         MEASURE: begin
            if (|err_set)     state_nxt = SEARCH;
            else if (vs_fall) state_nxt = LOCKED;
         end
         LOCKED:  if (|err_set) state_nxt = SEARCH;
         default: state_nxt = SEARCH;
      endcase
   end

   assign locked = (state == LOCKED);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= SEARCH;
         hs_q        <= 1'b1;
         vs_q        <= 1'b1;
         av_q        <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         av_run      <= '0;
         a_lines     <= '0;
         line_act    <= 1'b0;
         h_armed     <= 1'b0;
         err_flags   <= '0;
         frame_count <= '0;
      end else begin
         state <= state_nxt;
         hs_q  <= hsync;
         vs_q  <= vsync;
         av_q  <= active_video;

         if (hs_fall)           h_cnt <= 11'd1;
         else if (h_cnt != '1)  h_cnt <= h_cnt + 11'd1;

         if (vs_fall)                     v_cnt <= 10'd1;
         else if (hs_fall && v_cnt != '1) v_cnt <= v_cnt + 10'd1;

         if (av_rise)                            av_run <= 11'd1;
         else if (active_video && av_run != '1)  av_run <= av_run + 11'd1;

         if (vs_fall) a_lines <= '0;
         else         a_lines <= a_lines_cur;

         line_act <= hs_fall ? 1'b0 : (line_act | av_fall);

         // The first line end after SEARCH has no trusted start point
         if (state == SEARCH) h_armed <= 1'b0;
         else if (hs_fall)    h_armed <= 1'b1;

         err_flags <= (clr_err ? 6'd0 : err_flags) | err_set;

         if (state == LOCKED && vs_fall && !(|err_set) && frame_count != '1)
            frame_count <= frame_count + 16'd1;
      end
   end

`ifdef VGA_CHK_POS_EN
   assign rec_x = av_q ? (av_run - 11'd1) : '0;
   assign rec_y = av_q ? a_lines : '0;
`endif

endmodule

// File: tb/tb_vga_timing_checker.sv
// Directed bench for vga_timing_checker using a scaled-down timing set so that
// many full frames fit in a short run.
module tb_vga_timing_checker;

   localparam int HV  = 8;
   localparam int HS  = 3;
   localparam int HBP = 3;
   localparam int HT  = 16;
   localparam int VV  = 6;
   localparam int VS  = 2;
   localparam int VBP = 1;
   localparam int VT  = 10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        hsync, vsync, active_video, clr_err;
   logic        locked;
   logic [5:0]  err_flags;
   logic [15:0] frame_count;
`ifdef VGA_CHK_POS_EN
   logic [10:0] rec_x;
   logic [9:0]  rec_y;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic        ln_lock [0:15];
   logic [5:0]  ln_err  [0:15];
   logic [15:0] ln_fc   [0:15];

   vga_timing_checker #(
      .H_VISIBLE(HV),
      .H_SYNC(HS),
      .H_TOTAL(HT),
      .V_VISIBLE(VV),
      .V_SYNC(VS),
      .V_TOTAL(VT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .hsync(hsync),
      .vsync(vsync),
      .active_video(active_video),
      .clr_err(clr_err),
      .locked(locked),
      .err_flags(err_flags),
      .frame_count(frame_count)
`ifdef VGA_CHK_POS_EN
      ,
      .rec_x(rec_x),
      .rec_y(rec_y)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One pixel clock: drive on the falling edge, return just after the rising edge
   task automatic tick(input logic hs, input logic vs, input logic av, input logic clr);
      @(negedge clk);
      hsync        = hs;
      vsync        = vs;
      active_video = av;
      clr_err      = clr;
      @(posedge clk);
      #1;
   endtask

   // Frame begins with coincident hsync/vsync falls; a line index of -1 injects no fault
   task automatic frame(input int n_lines, input int n_act, input int long_line,
                        input int short_hs_line, input int clr_line);
      int   hlen, hslow;
      logic act, vs;
      for (int l = 0; l < n_lines; l++) begin
         hlen  = HT + ((l == long_line) ? 1 : 0);
         hslow = HS - ((l == short_hs_line) ? 1 : 0);
         act   = (l >= VS + VBP) && (l < VS + VBP + n_act);
         vs    = (l >= VS);
         for (int p = 0; p < hlen; p++) begin
            tick(p >= hslow, vs, act && (p >= HS + HBP) && (p < HS + HBP + HV),
                 (p == 0) && (l == clr_line));
            if (p == 0) begin
               ln_lock[l] = locked;
               ln_err[l]  = err_flags;
               ln_fc[l]   = frame_count;
            end
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; hsync = 1'b1; vsync = 1'b1; active_video = 1'b0; clr_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_locked", locked, 0);
      check("rst_err", err_flags, 0);
      check("rst_fc", frame_count, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b0);
      check("idle_locked", locked, 0);

      frame(VT, VV, -1, -1, -1);
      check("A_lock", ln_lock[0], 0);
      frame(VT, VV, -1, -1, -1);
      check("B_lock", ln_lock[0], 1);
      check("B_fc", ln_fc[0], 0);
      frame(VT, VV, -1, -1, -1);
      check("C_lock", ln_lock[0], 1);
      check("C_fc", ln_fc[0], 1);
      check("C_err", ln_err[0], 0);

      frame(VT, VV, 4, -1, -1);
      check("D_fc0", ln_fc[0], 2);
      check("D_lock4", ln_lock[4], 1);
      check("D_lock5", ln_lock[5], 0);
      check("D_err5", ln_err[5], 16'h02);
      check("D_fc5", ln_fc[5], 2);
      frame(VT, VV, -1, -1, -1);
      check("E_lock", ln_lock[0], 0);
      frame(VT, VV, -1, -1, -1);
      check("F_lock", ln_lock[0], 1);
      check("F_fc", ln_fc[0], 2);

      frame(VT, VV, -1, 3, 5);
      check("G_fc0", ln_fc[0], 3);
      check("G_lock3", ln_lock[3], 1);
      check("G_lock4", ln_lock[4], 0);
      check("G_err4", ln_err[4], 16'h03);
      check("G_err_clr", ln_err[5], 0);
      frame(VT, VV, -1, -1, -1);
      check("H_lock", ln_lock[0], 0);
      check("H_err", ln_err[0], 0);
      frame(VT, VV - 1, -1, -1, -1);
      check("I_lock", ln_lock[0], 1);
      check("I_fc", ln_fc[0], 3);
      frame(VT, VV, -1, -1, -1);
      check("J_lock", ln_lock[0], 0);
      check("J_err", ln_err[0], 16'h20);
      check("J_fc", ln_fc[0], 3);

      frame(VT, VV, -1, -1, -1);
      check("K_lock", ln_lock[0], 0);
      frame(VT, VV, -1, -1, -1);
      check("L_lock", ln_lock[0], 1);
      check("L_fc", ln_fc[0], 3);
      frame(5, VV, -1, -1, -1);
      check("M_lock", ln_lock[0], 1);
      check("M_fc", ln_fc[0], 4);
      reset_n = 1'b0;
      #1;
      check("mid_rst_locked", locked, 0);
      check("mid_rst_err", err_flags, 0);
      check("mid_rst_fc", frame_count, 0);
      repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) tick(1'b1, 1'b1, 1'b0, 1'b0);

      frame(VT, VV, -1, -1, -1);
      check("N_lock", ln_lock[0], 0);
      frame(VT, VV, -1, -1, -1);
      check("O_lock", ln_lock[0], 1);
      check("O_fc", ln_fc[0], 0);
      check("O_err", ln_err[0], 0);
      frame(VT, VV, -1, -1, -1);
      check("P_lock", ln_lock[0], 1);
      check("P_fc", ln_fc[0], 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_checker.md
VGA_TIMING_CHECKER -- requirements
Module: vga_timing_checker

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_SYNC, default 96, hsync low width in clocks.
REQ-003 SHALL have parameter H_TOTAL, default 800, clocks per line.
REQ-004 SHALL have parameter V_VISIBLE, default 480, active lines per frame.
REQ-005 SHALL have parameter V_SYNC, default 2, vsync low width in lines.
REQ-006 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-007 SHALL have port clk, input, 1, pixel clock; all logic on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port hsync, input, 1, monitored horizontal sync, active low.
REQ-010 SHALL have port vsync, input, 1, monitored vertical sync, active low.
REQ-011 SHALL have port active_video, input, 1, monitored display-enable.
REQ-012 SHALL have port clr_err, input, 1, synchronous clear of err_flags.
REQ-013 SHALL have port locked, output, 1, a full frame has matched all parameters.
REQ-014 SHALL have port err_flags, output, 6, sticky errors: [0] hsync width, [1] line length, [2] active width, [3] vsync width, [4] frame length, [5] active lines.
REQ-015 SHALL have port frame_count, output, 16, count of good frames completed while locked.

Function
REQ-016 SHALL register hsync, vsync, active_video once; an edge is the current input differing from the registered copy; all updates occur on the clk edge at which the edge is first sampled.
REQ-017 SHALL keep h_cnt (11 bit), cleared to 1 on hsync fall, incremented each clock, saturating at 2047.
REQ-018 SHALL keep v_cnt (10 bit), cleared to 1 on vsync fall, incremented on each hsync fall otherwise, saturating at 1023.
REQ-019 SHALL check on hsync rise that h_cnt == H_SYNC, else set err_flags[0].
REQ-020 SHALL check on hsync fall (excluding the first after SEARCH) that h_cnt == H_TOTAL, else set err_flags[1].
REQ-021 SHALL count active_video high clocks per line; on active_video fall, the run SHALL equal H_VISIBLE, else set err_flags[2]; lines containing such a run count as active lines.
REQ-022 SHALL check on vsync rise that v_cnt == V_SYNC, else set err_flags[3].
REQ-023 SHALL check on vsync fall (outside SEARCH) that v_cnt == V_TOTAL (err_flags[4]) and active lines == V_VISIBLE (err_flags[5]), then clear the active-line count.
REQ-024 SHALL implement states SEARCH, MEASURE, LOCKED: SEARCH->MEASURE on vsync fall; MEASURE->LOCKED on next vsync fall if no check failed during the frame; any failed check in MEASURE or LOCKED->SEARCH on that same clock.
REQ-025 SHALL drive locked high exactly in LOCKED.
REQ-026 SHALL increment frame_count on each vsync fall in LOCKED with no failure, saturating at 65535; it SHALL hold on lock loss.
REQ-027 SHALL give a new error set priority over clr_err in the same cycle.
REQ-028 SHALL treat simultaneous hsync and vsync falls as line end then frame end, both checked in that cycle.

Reset
REQ-029 SHALL, while reset_n low, force state SEARCH, locked 0, err_flags 0, frame_count 0, all counters and input registers 0 (registered syncs to 1).
REQ-030 SHALL abandon any partial measurement on reset mid-frame and restart from SEARCH.

Configuration
REQ-031 SHALL, with VGA_CHK_POS_EN defined, add outputs rec_x (11 bit) and rec_y (10 bit): pixel index within active run and active-line index, 0 outside active video; without it neither port nor logic exists.

Verification
REQ-032 SHALL verify: vga_controller-compliant 640x480 stream, 3 frames -> locked high at second frame's vsync fall, frame_count 1 at third, err_flags 0.
REQ-033 SHALL verify: one line with H_TOTAL 801 while locked -> err_flags[1]=1, locked 0 same cycle, relock after two clean frames.
REQ-034 SHALL verify: hsync low 95 clocks -> err_flags[0]=1; clr_err pulse -> err_flags 0 next cycle.
REQ-035 SHALL verify: frame of 479 active lines -> err_flags[5]=1 and err_flags[4]=1 not set if V_TOTAL 525 kept.
REQ-036 SHALL verify: reset_n low mid-frame while locked -> all outputs 0 immediately, locked again two frames after release.
